// File: rtl/bcd_add_serial.sv
// ---------------------------------------------------------------------------
// bcd_add_serial
//
// Byte-serial packed-BCD adder. The operands are N bytes wide, two BCD digits
// per byte. One byte (two digits) is added per clock, least significant byte
// first, behind a ld / busy / done handshake. This is the area-lean partner of
// the pipelined BCD subtractor and uses the same operand format.
//
// Parameters
//   N     operand width in bytes (2N digits, 8N bits), legal range 1..64
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   ld    in   start request, sampled only while busy is low (IDLE or DONE)
//   a     in   [8N-1:0] addend A, packed BCD
//   b     in   [8N-1:0] addend B, packed BCD
//   ci    in   decimal carry in
//   o     out  [8N-1:0] sum, packed BCD (holds until the next completion)
//   co    out  decimal carry out of the most significant digit
//   busy  out  operation in progress
//   done  out  one-cycle pulse, o/co/inv valid
//   inv   out  invalid-digit flag
//
// Configuration
//   BCD_ADD_INVALID_CHK_EN  when defined, every processed A/B nibble is checked
//                           for a value above 9; a sticky flag collects hits and
//                           is copied to inv on completion. When undefined,
//                           inv is tied low and no checking logic is built.
//                           The sum datapath is identical in both builds.
//
// Timing
//   ld sampled at edge T -> bytes 0..N-1 are added on edges T+1..T+N,
//   o/co update at edge T+N and done is high for the cycle after it.
//   A ld sampled during the DONE cycle starts the next operation directly,
//   giving one result every N+1 cycles.
// ---------------------------------------------------------------------------
module bcd_add_serial #(
  parameter int N = 33
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [8*N-1:0] a,
  input  logic [8*N-1:0] b,
  input  logic           ci,
  output logic [8*N-1:0] o,
  output logic           co,
  output logic           busy,
  output logic           done,
  output logic           inv
);

  // Counter must hold 0..N-1; keep at least one bit for N=1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One decimal digit add: returns {carry, digit}. The sum is formed in five
  // bits; anything above 9 gets +6, which wraps the low nibble back into
  // 0..9 for legal inputs (max 9+9+1 = 19 -> 25 -> digit 9, carry 1).
  // Illegal nibbles go through the same rule and give a deterministic value.
  function automatic logic [4:0] bcd_digit(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (s > 5'd9) begin
      bcd_digit = {1'b1, s[3:0] + 4'd6};
    end else begin
      bcd_digit = {1'b0, s[3:0]};
    end
  endfunction

  // True when either digit of a byte is not a legal BCD value.
  function automatic logic byte_invalid(input logic [7:0] v);
    byte_invalid = (v[3:0] > 4'd9) | (v[7:4] > 4'd9);
  endfunction

  // State and datapath registers
  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [8*N-1:0] a_q, a_d;
  logic [8*N-1:0] b_q, b_d;
  logic [8*N-1:0] res_q, res_d;
  logic           carry_q, carry_d;
  logic [8*N-1:0] o_q, o_d;
  logic           co_q, co_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Combinational helpers
  logic [4:0]     lo_s;
  logic [4:0]     hi_s;
  logic [7:0]     sum_byte_s;
  logic [8*N+7:0] res_cat_s;
  logic [8*N-1:0] res_next_s;
  logic           last_s;
  logic           accept_s;

  // Current byte sits in the low 8 bits of the operand shift registers.
  assign lo_s       = bcd_digit(a_q[3:0], b_q[3:0], carry_q);
  assign hi_s       = bcd_digit(a_q[7:4], b_q[7:4], lo_s[4]);
  assign sum_byte_s = {hi_s[3:0], lo_s[3:0]};

  // Result bytes enter at the top and move down, so after N bytes byte 0 is
  // at the bottom. The concatenation form also works for N=1.
  assign res_cat_s  = {sum_byte_s, res_q};
  assign res_next_s = res_cat_s[8*N+7:8];

  assign last_s   = (cnt_q == CNT_LAST);
  assign accept_s = ld & ((state_q == ST_IDLE) | (state_q == ST_DONE));

`ifdef BCD_ADD_INVALID_CHK_EN
  logic sticky_q, sticky_d;
  logic inv_q, inv_d;
  logic hit_s;

  assign hit_s = byte_invalid(a_q[7:0]) | byte_invalid(b_q[7:0]);
`endif

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    o_d     = o_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_ADD_INVALID_CHK_EN
    sticky_d = sticky_q;
    inv_d    = inv_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          busy_d  = 1'b1;
`ifdef BCD_ADD_INVALID_CHK_EN
          sticky_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> 4'd8;
        b_d     = b_q >> 4'd8;
        res_d   = res_next_s;
        carry_d = hi_s[4];
        cnt_d   = cnt_q + CW'(1);
`ifdef BCD_ADD_INVALID_CHK_EN
        sticky_d = sticky_q | hit_s;
`endif
        if (last_s) begin
          // Publish the result on the same edge that stores the last byte.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          o_d     = res_next_s;
          co_d    = hi_s[4];
`ifdef BCD_ADD_INVALID_CHK_EN
          inv_d   = sticky_q | hit_s;
`endif
        end else begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      o_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      o_q     <= o_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_ADD_INVALID_CHK_EN
  // Invalid-digit tracking registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      inv_q    <= inv_d;
    end
  end

  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  assign o    = o_q;
  assign co   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_add_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_add_serial
//
// Directed, table-driven bench for bcd_add_serial. A 4-byte instance carries
// the main vectors plus hand-written sequences for back-to-back ld, operand
// changes mid-run and reset mid-run; a 1-byte instance covers the N=1 case.
// Expected inv depends on whether BCD_ADD_INVALID_CHK_EN is defined.
// ---------------------------------------------------------------------------
module tb_bcd_add_serial;

`ifdef BCD_ADD_INVALID_CHK_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif

  localparam int NB = 4;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [31:0] a, b;
  logic        ci;
  logic [31:0] o;
  logic        co, busy, done, inv;

  logic        ld1;
  logic [7:0]  a1, b1;
  logic        ci1;
  logic [7:0]  o1;
  logic        co1, busy1, done1, inv1;

  int n_err;
  int n_checks;

  bcd_add_serial #(.N(NB)) dut (
    .clk(clk), .rst(rst), .ld(ld), .a(a), .b(b), .ci(ci),
    .o(o), .co(co), .busy(busy), .done(done), .inv(inv)
  );

  bcd_add_serial #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .ld(ld1), .a(a1), .b(b1), .ci(ci1),
    .o(o1), .co(co1), .busy(busy1), .done(done1), .inv(inv1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vci;
    logic [31:0] eo;
    logic        eco;
    logic        einv;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete operation on the 4-byte instance, including latency check.
  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic vci, input logic [31:0] eo, input logic eco,
                        input logic einv);
    int  k;
    bit  seen;
    @(negedge clk);
    ld = 1'b1; a = va; b = vb; ci = vci;
    @(posedge clk);
    #1;
    ld = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
    check({name, " busy"}, 32'(busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else k++;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL %s timeout: no done within 20 cycles", name);
    end else begin
      check({name, " latency"}, 32'(k), 32'(NB));
      check({name, " o"}, o, eo);
      check({name, " co"}, 32'(co), 32'(eco));
      check({name, " inv"}, 32'(inv), 32'(einv));
      check({name, " busy@done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int  k;
    bit  seen;
    int  pulses;

    n_err = 0;
    n_checks = 0;
    rst = 1'b1;
    ld = 1'b0; a = '0; b = '0; ci = 1'b0;
    ld1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;

    vecs[0] = '{32'h99999999, 32'h99999999, 1'b1, 32'h99999999, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vecs[2] = '{32'h00000001, 32'h00000009, 1'b0, 32'h00000010, 1'b0, 1'b0};
    vecs[3] = '{32'h00000045, 32'h00000055, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[4] = '{32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[6] = '{32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, INV_EN};
    vecs[7] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[8] = '{32'h00580937, 32'h00460188, 1'b0, 32'h01041125, 1'b0, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst o", o, 32'd0);
    check("rst co", 32'(co), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst inv", 32'(inv), 32'd0);
    rst = 1'b0;

    // Table of directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vci,
             vecs[i].eo, vecs[i].eco, vecs[i].einv);
    end

    // Leave a non-zero o and co=1 behind, then reset mid-run
    run_op("pre_rst", 32'h99999999, 32'h00000002, 1'b0, 32'h00000001, 1'b1, 1'b0);
    @(negedge clk);
    ld = 1'b1; a = 32'h12345678; b = 32'h11111111; ci = 1'b0;
    @(posedge clk);
    #1 ld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst o", o, 32'd0);
    check("midrst co", 32'(co), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst no done", 32'(pulses), 32'd0);
    run_op("post_rst", 32'h50000000, 32'h50000000, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // ld held high, operands changing every cycle: results every NB+1 cycles
    @(negedge clk);
    ld = 1'b1; a = 32'h00000005; b = 32'h00000005; ci = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("held done c%0d", c), 32'(done), 32'((c == 4) || (c == 9)));
      if (c == 4) begin
        check("held o1", o, 32'h00000010);
        check("held co1", 32'(co), 32'd0);
      end
      if (c == 5) check("held busy c5", 32'(busy), 32'd1);
      if (c == 9) begin
        check("held o2", o, 32'h60606060);
        check("held co2", 32'(co), 32'd0);
      end
      if (c + 1 == 5) begin
        a = 32'h55555555; b = 32'h05050505; ci = 1'b0;
      end else begin
        a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      end
    end
    ld = 1'b0;
    repeat (NB + 3) @(negedge clk);

    // N=1 instance
    @(negedge clk);
    ld1 = 1'b1; a1 = 8'h95; b1 = 8'h07; ci1 = 1'b0;
    @(posedge clk);
    #1;
    ld1 = 1'b0; a1 = 8'hFF; b1 = 8'hFF;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
      else k++;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL n1 timeout: no done within 10 cycles");
    end else begin
      check("n1 latency", 32'(k), 32'd1);
      check("n1 o", 32'(o1), 32'h02);
      check("n1 co", 32'(co1), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_add_serial.md
Name: bcd_add_serial

Overview:
- Byte-serial packed-BCD adder: the addition counterpart of the team's pipelined BCD subtractor, sharing its operand format (N bytes, two BCD digits per byte, 8N bits).
- Processes one byte (two digits) per clock, LSB byte first, behind a start/done handshake.
- Trades latency for area. Used in the decimal FPU wherever an add result is not timing-critical, such as mantissa rounding increment and exponent adjust.

Parameters:
- N, 33, operand width in bytes (2N BCD digits, 8N bits); legal range 1..64.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- ld  in  1  start request; sampled only when busy=0.
- a  in  8N  addend A, packed BCD.
- b  in  8N  addend B, packed BCD.
- ci  in  1  decimal carry in.
- o  out  8N  sum, packed BCD.
- co  out  1  decimal carry out of most significant digit.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: o/co valid.
- inv  out  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (async, immediate): state=IDLE; o=0, co=0, busy=0, done=0, inv=0; byte counter=0; internal operand registers=0.
- State IDLE:
  - ld=1 at a rising edge: capture a, b, ci into internal registers; clear counter; go to RUN; busy=1 from that edge.
  - ld=0: remain IDLE.
  - o and co hold their last values.
- State RUN, each edge processes byte index cnt:
  - Low digit: s = a.lo + b.lo + carry. If s>9, s+=6 and digit carry=1.
  - High digit: same rule, using the low digit's carry.
  - Store the result byte into the result shift register; carry register = high-digit carry.
  - cnt increments. When cnt reaches N-1 on this edge, go to DONE.
- State DONE:
  - Lasts exactly one cycle. done=1, busy=0, o=assembled result, co=final carry.
  - Next edge goes to IDLE. A ld sampled in DONE is accepted exactly as in IDLE, allowing back-to-back operations.
- Latency: ld sampled at edge T → done high during cycle following edge T+N. o/co update at edge T+N and hold until the next completion.
- Throughput: one operation per N+1 cycles.
- ld while busy=1 (RUN): ignored, no queueing. a/b/ci may change freely after the accepting edge.
- Width rules:
  - Digit arithmetic is 5-bit internally.
  - Max per-digit sum is 9+9+1=19 → 19+6, low nibble 9, carry 1. One adjust per digit suffices.
- Invalid inputs (nibble >9): sum still computed with the same rule. Result is deterministic but not meaningful decimal; no other effect unless the feature is enabled.
- Reset asserted mid-RUN: operation aborted, done never pulses for it, all outputs return to reset values immediately.
- N=1: RUN lasts one cycle.

Optional Feature:
- Macro BCD_ADD_INVALID_CHK_EN.
- Defined:
  - During RUN, each processed A/B nibble is checked for >9; a sticky flag is set on any hit.
  - At the DONE edge, inv is loaded with the sticky flag and holds until the next completion or reset.
  - The sticky flag clears on ld acceptance.
- Undefined: inv tied to 0, no checking logic.
- Datapath results are identical either way.

Test Plan (N=4 unless stated):
- a=0x99999999, b=0x99999999, ci=1, pulse ld → done exactly 4 cycles after the ld edge; o=0x99999999, co=1, inv=0.
- a=0x12345678, b=0x87654321, ci=0 → o=0x99999999, co=0; then a=0x00000001, b=0x00000009, ci=0 → o=0x00000010, co=0.
- ld held high continuously with a=0x00000005, b=0x00000005, changing a/b every cycle → one result per 5 cycles (o=0x00000010 for first). Operands changed mid-RUN do not affect the in-flight result.
- Assert rst 2 cycles after ld → o=0, co=0, busy=0 immediately; no done pulse; next ld with a=0x50000000, b=0x50000000 gives o=0x00000000, co=1.
- With BCD_ADD_INVALID_CHK_EN: a=0x0000000A, b=0, ci=0 → done with inv=1. Following valid op a=1, b=1 → o=0x00000002, inv=0. Without the macro, inv stays 0.
- N=1: a=0x95, b=0x07, ci=0 → done 1 cycle after ld edge, o=0x02, co=1.
